// File: rtl/project_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO: register select, write strobe and registered read
// data.
interface project_led_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/project_led_pio.sv
// LED parallel output port with set/clear registers and a per-bit blink mask driven by a
// free-running half-period counter.
module project_led_pio #(
    parameter int unsigned WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    project_led_pio_if.slave bus,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned      CntWidth  = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(BLINK_DIV - 1);
    localparam logic [WIDTH-1:0] ResetData = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    wdata;
    logic [CntWidth-1:0] cnt_q;
    logic                phase_q;
    logic                wr_en;
    logic                mask_wr;
    logic [31:0]         rdata_d;
    logic                unused_wdata;

    // Upper writedata bits beyond WIDTH carry no meaning.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        wr_en   = bus.chipselect && !bus.write_n;
        wdata   = bus.writedata[WIDTH-1:0];
        data_d  = data_q;
        mask_d  = mask_q;
        mask_wr = 1'b0;
        if (wr_en) begin
            case (bus.address)
                2'd0: data_d = wdata;
                2'd1: begin
                    mask_d  = wdata;
                    mask_wr = 1'b1;
                end
                2'd2: data_d = data_q | wdata;
                2'd3: data_d = data_q & ~wdata;
                default: ;
            endcase
        end
    end

    // Read mux looks at next-state values so a read right after a write returns the new value.
    always_comb begin
        rdata_d = '0;
        case (bus.address)
            2'd0: rdata_d[WIDTH-1:0] = data_d;
            2'd1: rdata_d[WIDTH-1:0] = mask_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q       <= ResetData;
            mask_q       <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            bus.readdata <= '0;
        end else begin
            data_q       <= data_d;
            mask_q       <= mask_d;
            bus.readdata <= rdata_d;
            if (mask_wr) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (cnt_q == CntMax) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_port = data_q ^ (mask_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_project_led_pio.sv
// Scoreboard bench for project_led_pio: a driver updates a cycle-count reference model and queues
// expectations; a monitor compares out_port/readdata after every clock edge.
module tb_project_led_pio;

    localparam int unsigned WIDTH       = 8;
    localparam logic [31:0] RESET_VALUE = 32'd0;
    localparam int unsigned BLINK_DIV   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;

    project_led_pio_if bus_if ();

    project_led_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic [31:0]      rd;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    // Reference model: blink phase derived from edges elapsed since the last mask write or reset.
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    logic [31:0]      m_rd;
    int               m_k;

    task automatic step(input bit rst_n, input bit cs, input bit wn, input logic [1:0] addr,
                        input logic [31:0] wd, input string tag);
        logic [WIDTH-1:0] w;
        bit               ph;
        exp_t             e;
        @(negedge clk);
        reset_n           = rst_n;
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.address    = addr;
        bus_if.writedata  = wd;
        w = wd[WIDTH-1:0];
        if (!rst_n) begin
            m_data = RESET_VALUE[WIDTH-1:0];
            m_mask = '0;
            m_k    = 0;
            m_rd   = 32'd0;
        end else begin
            m_k = m_k + 1;
            if (cs && !wn) begin
                if (addr == 2'd0) m_data = w;
                if (addr == 2'd1) begin
                    m_mask = w;
                    m_k    = 0;
                end
                if (addr == 2'd2) m_data = m_data | w;
                if (addr == 2'd3) m_data = m_data & ~w;
            end
            m_rd = (addr == 2'd0) ? {24'd0, m_data} : (addr == 2'd1) ? {24'd0, m_mask} : 32'd0;
        end
        ph    = ((m_k / BLINK_DIV) % 2) == 1;
        e.out = m_data ^ (m_mask & {WIDTH{ph}});
        e.rd  = m_rd;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input int n, input logic [1:0] addr, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, addr, $urandom, tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd, input string tag);
        step(1'b1, 1'b1, 1'b0, addr, wd, tag);
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_vec++;
                if (out_port !== e.out || bus_if.readdata !== e.rd) begin
                    n_bad++;
                    $display("FAIL %s: got out_port=%h readdata=%h, want out_port=%h readdata=%h",
                             t, out_port, bus_if.readdata, e.out, e.rd);
                end
            end
        end
    end

    initial begin : driver
        reset_n           = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = 32'd0;

        step(1'b0, 1'b1, 1'b0, 2'd0, 32'hFF, "reset_with_write");
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, "reset");
        idle(100, 2'd0, "idle_after_reset");

        wr(2'd0, 32'hA5, "write_data");
        idle(2, 2'd0, "read_data");
        wr(2'd2, 32'h0F, "outset");
        wr(2'd3, 32'hA0, "outclear");
        idle(1, 2'd2, "read_outset");
        idle(1, 2'd3, "read_outclear");

        wr(2'd0, 32'h01, "blink_data");
        wr(2'd1, 32'h03, "blink_mask");
        idle(16, 2'd1, "blinking");
        wr(2'd1, 32'h00, "blink_off");
        idle(6, 2'd0, "steady");

        step(1'b1, 1'b0, 1'b0, 2'd0, 32'hFF, "cs_gating");
        wr(2'd0, 32'hFFFF_FF00, "upper_bits_ignored");

        wr(2'd0, 32'h3C, "mid_data");
        wr(2'd1, 32'hFF, "mid_mask");
        idle(6, 2'd0, "mid_blink");
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'hFF, "reset_mid_blink");
        idle(1, 2'd1, "mask_after_reset");
        wr(2'd0, 32'h81, "first_write_after_reset");
        idle(9, 2'd0, "post_reset_static");

        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 2'($urandom_range(0, 3)), $urandom, "random");
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
